// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor.
//   - state_t   : FSM state encoding (IDLE / SHIFT / DONE)
//   - N_DEFAULT : default operand width
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// -----------------------------------------------------------------------------
// full_sub
//   Combinational 1-bit full subtractor: computes a - b - bin.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  borrow in
//     d    out 1  difference bit
//     bout out 1  borrow out
// -----------------------------------------------------------------------------
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit subtractor: diff = a - b - bin (mod 2^N), LSB first,
//   one bit per clock through a single full_sub cell and a borrow flip-flop.
//   Ports:
//     clk    in  1  clock, rising edge
//     rst_n  in  1  synchronous reset, active-low
//     start  in  1  load operands and begin (honoured only in IDLE or DONE)
//     a      in  N  minuend
//     b      in  N  subtrahend
//     bin    in  1  borrow in
//     busy   out 1  high while bits are being processed
//     done   out 1  one-cycle pulse, diff/bout valid
//     diff   out N  registered difference, held until next completion
//     bout   out 1  registered final borrow (1 => a < b + bin, unsigned)
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
);

    localparam int                CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

    state_t             state_reg;
    logic [N-1:0]       a_sr_reg;
    logic [N-1:0]       b_sr_reg;
    // Result shift register keeps only the upper N-1 bits: the bit that would
    // fall out of the bottom is never needed, because the final word is taken
    // straight from res_sr_next on the last bit.
    logic [N-2:0]       res_sr_reg;
    logic               br_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [N-1:0]       diff_reg;
    logic               bout_reg;

    logic               cell_d;
    logic               cell_bout;
    logic [N-1:0]       res_sr_next;
    logic [N-1:0]       a_shift_next;
    logic [N-1:0]       b_shift_next;

    full_sub u_full_sub (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .bin  (br_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New difference bit enters at the MSB side; after N bits the LSB of the
    // result has walked down to bit 0.
    assign res_sr_next = {cell_d, res_sr_reg};

    // Logical right shift of the operand registers.
    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_shift
            assign a_shift_next[gi] = a_sr_reg[gi+1];
            assign b_shift_next[gi] = b_sr_reg[gi+1];
        end
    endgenerate
    assign a_shift_next[N-1] = 1'b0;
    assign b_shift_next[N-1] = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            res_sr_reg <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_sr_reg   <= a;
                        b_sr_reg   <= b;
                        br_reg     <= bin;
                        res_sr_reg <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    a_sr_reg   <= a_shift_next;
                    b_sr_reg   <= b_shift_next;
                    br_reg     <= cell_bout;
                    res_sr_reg <= res_sr_next[N-1:1];
                    cnt_reg    <= cnt_reg + 1'b1;
                    // start is deliberately not looked at here.
                    if (cnt_reg == CNT_LAST) begin
                        diff_reg  <= res_sr_next;
                        bout_reg  <= cell_bout;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        // Back-to-back: skip IDLE and load the next operands.
                        a_sr_reg   <= a;
                        b_sr_reg   <= b;
                        br_reg     <= bin;
                        res_sr_reg <= '0;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= S_SHIFT;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end

                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;

    int checks;
    int errors;

    // Last completed result, as predicted by the reference model.
    logic [N-1:0] held_diff;
    logic         held_bout;

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction.
    function automatic logic [N-1:0] ref_diff(input int ia, input int ib, input int ibin);
        int r;
        r = ia - ib - ibin;
        if (r < 0) r = r + (1 << N);
        return r[N-1:0];
    endfunction

    function automatic logic ref_bout(input int ia, input int ib, input int ibin);
        return (ia < ib + ibin);
    endfunction

    // Called at a negedge. Drives start for one cycle, optionally re-pulses
    // start with junk operands while busy, waits (bounded) for done and
    // checks latency, busy width, output hold, and the result.
    // Returns at the negedge on which done was seen.
    task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic tbin, input bit repulse);
        int busy_cnt;
        int lat;
        bit seen;
        logic [N-1:0] ed;
        logic         eb;
        ed = ref_diff(int'(ta), int'(tb), int'(tbin));
        eb = ref_bout(int'(ta), int'(tb), int'(tbin));
        start = 1'b1; a = ta; b = tb; bin = tbin;
        busy_cnt = 0; lat = 0; seen = 1'b0;
        for (int k = 1; k <= 3 * N + 4; k++) begin
            @(negedge clk);
            if (repulse && k <= N - 1) begin
                start = 1'b1;
                a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
            end else begin
                start = 1'b0;
                a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
            end
            if (done) begin
                lat = k;
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            chk({tag, "_hold_diff"}, diff, held_diff);
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_latency"}, lat, N + 1);
            chk({tag, "_busy_cycles"}, busy_cnt, N);
            chk({tag, "_busy_at_done"}, busy, 1'b0);
            chk({tag, "_diff"}, diff, ed);
            chk({tag, "_bout"}, bout, eb);
        end
        held_diff = ed;
        held_bout = eb;
        $display("op %s a=%0h b=%0h bin=%0d -> diff=%0h bout=%0d (exp %0h/%0d)",
                 tag, ta, tb, tbin, diff, bout, ed, eb);
    endtask

    // One cycle past a non-chained completion: done must be gone, results held.
    task automatic after_done(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_held_diff"}, diff, held_diff);
        chk({tag, "_held_bout"}, bout, held_bout);
    endtask

    initial begin
        checks = 0; errors = 0;
        held_diff = '0; held_bout = 1'b0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_diff", diff, 4'b0000);
        chk("reset_bout", bout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_op("t1", 4'b1001, 4'b0011, 1'b0, 1'b0);
        after_done("t1");
        do_op("t2", 4'b0011, 4'b0101, 1'b0, 1'b0);
        after_done("t2");
        do_op("t3", 4'b0000, 4'b0000, 1'b1, 1'b0);
        after_done("t3");
        do_op("t4_repulse", 4'b1100, 4'b0101, 1'b1, 1'b1);
        after_done("t4");
        // Back-to-back: second start issued on the DONE cycle.
        do_op("t5a", 4'b0111, 4'b0010, 1'b0, 1'b0);
        do_op("t5b", 4'b1111, 4'b0001, 1'b0, 1'b0);
        after_done("t5b");

        // Reset in the middle of an operation (asserted for edge 2).
        start = 1'b1; a = 4'b1010; b = 4'b0001; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        held_diff = '0; held_bout = 1'b0;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_diff", diff, 4'b0000);
        chk("t6_rst_bout", bout, 1'b0);
        for (int k = 0; k < N + 2; k++) begin
            @(negedge clk);
            chk("t6_no_done", done, 1'b0);
        end
        $display("op t6 reset mid-op -> busy=%0d done=%0d diff=%0h bout=%0d", busy, done, diff, bout);

        // Random operations.
        for (int i = 0; i < 10; i++) begin
            do_op("rnd", N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) after_done("rnd");
        end
        after_done("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
